// File: rtl/fifo_sync_level.sv
// Single-clock FIFO with occupancy level, almost-full/almost-empty flags and synchronous flush.
// Define FIFO_SYNC_LEVEL_ERR_EN to build the sticky OVERFLOW/UNDERFLOW error flags.
module fifo_sync_level #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 2,
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = (1 << DEPTH_LOG2) - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  CLR,
    input  logic                  W_nEN,
    input  logic [DATA_WIDTH-1:0] W_DATA,
    output logic                  W_FULL,
    input  logic                  R_nEN,
    output logic [DATA_WIDTH-1:0] R_DATA,
    output logic                  R_EMPTY,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  A_FULL,
    output logic                  A_EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int                 D        = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] AFULL_L  = AFULL_LEVEL[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] AEMPTY_L = AEMPTY_LEVEL[DEPTH_LOG2:0];

    logic [DATA_WIDTH-1:0] r_mem [D];
    logic [DEPTH_LOG2:0]   r_wptr;
    logic [DEPTH_LOG2:0]   r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [DEPTH_LOG2:0]   w_level_nxt;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                     (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
    assign w_push  = !W_nEN && !w_full && !CLR;
    assign w_pop   = !R_nEN && !w_empty && !CLR;

    assign W_FULL  = w_full;
    assign R_EMPTY = w_empty;
    assign LEVEL   = r_level;
    assign A_FULL  = (r_level >= AFULL_L);
    assign A_EMPTY = (r_level <= AEMPTY_L);

    // Next occupancy from the accepted push/pop pair; flush wins.
    always_comb begin
        w_level_nxt = r_level;
        if (CLR) begin
            w_level_nxt = {(DEPTH_LOG2+1){1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_level_nxt = r_level + PTR_ONE;
                2'b01:   w_level_nxt = r_level - PTR_ONE;
                default: w_level_nxt = r_level;
            endcase
        end
    end

    // Pointer and level registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wptr  <= {(DEPTH_LOG2+1){1'b0}};
            r_rptr  <= {(DEPTH_LOG2+1){1'b0}};
            r_level <= {(DEPTH_LOG2+1){1'b0}};
        end else if (CLR) begin
            r_wptr  <= {(DEPTH_LOG2+1){1'b0}};
            r_rptr  <= {(DEPTH_LOG2+1){1'b0}};
            r_level <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_level <= w_level_nxt;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= W_DATA;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign R_DATA = r_mem[r_rptr[DEPTH_LOG2-1:0]];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_rdata;

            // Output register captures the head entry on each accepted pop.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_rdata <= {DATA_WIDTH{1'b0}};
                end else if (w_pop) begin
                    r_rdata <= r_mem[r_rptr[DEPTH_LOG2-1:0]];
                end else begin
                    r_rdata <= r_rdata;
                end
            end

            assign R_DATA = r_rdata;
        end
    endgenerate

`ifdef FIFO_SYNC_LEVEL_ERR_EN
    logic r_ovf;
    logic r_udf;

    // Sticky error flags; a request coinciding with flush is not an error.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (CLR) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (!W_nEN && w_full);
            r_udf <= r_udf | (!R_nEN && w_empty);
        end
    end

    assign OVERFLOW  = r_ovf;
    assign UNDERFLOW = r_udf;
`else
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_level.sv
// Self-checking bench for fifo_sync_level: a registered-read and a FWFT instance share stimulus
// and are compared against a queue-based reference model.
module tb_fifo_sync_level;

    localparam int D = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        CLR = 1'b0;
    logic        W_nEN = 1'b1;
    logic [31:0] W_DATA = 32'h0;
    logic        R_nEN = 1'b1;
    logic        W_FULL, R_EMPTY, A_FULL, A_EMPTY, OVERFLOW, UNDERFLOW;
    logic [31:0] R_DATA;
    logic [2:0]  LEVEL;
    logic        f_w_full, f_r_empty, f_a_full, f_a_empty, f_ovf, f_udf;
    logic [31:0] f_r_data;
    logic [2:0]  f_level;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [31:0] m_rdata = 32'h0;
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    always #5 CLK = ~CLK;

    fifo_sync_level dut (
        .CLK(CLK), .nRST(nRST), .CLR(CLR), .W_nEN(W_nEN), .W_DATA(W_DATA), .W_FULL(W_FULL),
        .R_nEN(R_nEN), .R_DATA(R_DATA), .R_EMPTY(R_EMPTY), .LEVEL(LEVEL), .A_FULL(A_FULL),
        .A_EMPTY(A_EMPTY), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    fifo_sync_level #(.FWFT(1)) dut_f (
        .CLK(CLK), .nRST(nRST), .CLR(CLR), .W_nEN(W_nEN), .W_DATA(W_DATA), .W_FULL(f_w_full),
        .R_nEN(R_nEN), .R_DATA(f_r_data), .R_EMPTY(f_r_empty), .LEVEL(f_level), .A_FULL(f_a_full),
        .A_EMPTY(f_a_empty), .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
    );

    wire [5:0] dut_flags = {R_EMPTY, W_FULL, A_EMPTY, A_FULL, OVERFLOW, UNDERFLOW};
    wire [5:0] f_flags   = {f_r_empty, f_w_full, f_a_empty, f_a_full, f_ovf, f_udf};

    // Expected {empty, full, a_empty, a_full, ovf, udf} from the model occupancy.
    function automatic logic [5:0] exp_flags();
        int n;
        n = q.size();
        return {n == 0, n == D, n <= 1, n >= D - 1, m_ovf, m_udf};
    endfunction

    task automatic model_reset();
        q.delete();
        m_rdata = 32'h0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // Apply one cycle of stimulus and advance the model at the clock edge.
    task automatic drive(input logic wn, input logic [31:0] wd, input logic rn, input logic clr);
        int  n;
        bit  full, empty;
        W_nEN = wn; W_DATA = wd; R_nEN = rn; CLR = clr;
        @(posedge CLK);
        n = q.size();
        full  = (n == D);
        empty = (n == 0);
        if (clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
`ifdef FIFO_SYNC_LEVEL_ERR_EN
            if (!wn && full)  m_ovf = 1'b1;
            if (!rn && empty) m_udf = 1'b1;
`endif
            if (!rn && !empty) m_rdata = q.pop_front();
            if (!wn && !full)  q.push_back(wd);
        end
        #1;
        W_nEN = 1'b1; R_nEN = 1'b1; CLR = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (dut_flags !== exp_flags() || LEVEL !== 3'd0 || R_DATA !== 32'h0) begin
            errors++;
            $display("FAIL reset flags=%b level=%0d rdata=%h expected flags=%b level=0 rdata=0",
                     dut_flags, LEVEL, R_DATA, exp_flags());
        end
        checks++;
        if (f_flags !== exp_flags() || f_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_fwft flags=%b level=%0d expected flags=%b level=0", f_flags, f_level, exp_flags());
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 32'(i), 1'b1, 1'b0);
            checks++;
            if (LEVEL !== 3'(i) || dut_flags !== exp_flags()) begin
                errors++;
                $display("FAIL fill level=%0d flags=%b expected level=%0d flags=%b", LEVEL, dut_flags, i, exp_flags());
            end
        end
    endtask

    task automatic test_overflow_drain();
        drive(1'b0, 32'h5, 1'b1, 1'b0);
        checks++;
        if (LEVEL !== 3'd4 || dut_flags !== exp_flags() || f_flags !== exp_flags()) begin
            errors++;
            $display("FAIL overflow level=%0d flags=%b fwft_flags=%b expected level=4 flags=%b",
                     LEVEL, dut_flags, f_flags, exp_flags());
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (f_r_data !== 32'(i)) begin
                errors++;
                $display("FAIL drain_fwft_head got=%h expected=%h", f_r_data, 32'(i));
            end
            drive(1'b1, 32'h0, 1'b0, 1'b0);
            checks++;
            if (R_DATA !== 32'(i) || dut_flags !== exp_flags()) begin
                errors++;
                $display("FAIL drain rdata=%h flags=%b expected rdata=%h flags=%b", R_DATA, dut_flags, 32'(i), exp_flags());
            end
        end
    endtask

    task automatic test_fwft();
        drive(1'b0, 32'hA5, 1'b1, 1'b0);
        checks++;
        if (f_r_empty !== 1'b0 || f_r_data !== 32'hA5) begin
            errors++;
            $display("FAIL fwft_visible empty=%b rdata=%h expected empty=0 rdata=a5", f_r_empty, f_r_data);
        end
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        checks++;
        if (f_r_empty !== 1'b1 || f_level !== 3'd0 || R_DATA !== 32'hA5) begin
            errors++;
            $display("FAIL fwft_pop empty=%b level=%0d reg_rdata=%h expected empty=1 level=0 reg_rdata=a5",
                     f_r_empty, f_level, R_DATA);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 32'h10, 1'b1, 1'b0);
        drive(1'b0, 32'h11, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 32'h12 + 32'(k), 1'b0, 1'b0);
            checks++;
            if (LEVEL !== 3'd2 || R_DATA !== 32'h10 + 32'(k) || f_r_data !== 32'h11 + 32'(k)) begin
                errors++;
                $display("FAIL back_to_back level=%0d rdata=%h fwft=%h expected level=2 rdata=%h fwft=%h",
                         LEVEL, R_DATA, f_r_data, 32'h10 + 32'(k), 32'h11 + 32'(k));
            end
        end
    endtask

    task automatic test_simul_edges();
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h7, 1'b0, 1'b0);
        checks++;
        if (LEVEL !== 3'd1 || dut_flags !== exp_flags() || f_r_data !== 32'h7) begin
            errors++;
            $display("FAIL push_pop_empty level=%0d flags=%b fwft=%h expected level=1 flags=%b fwft=7",
                     LEVEL, dut_flags, f_r_data, exp_flags());
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h20 + 32'(i), 1'b1, 1'b0);
        drive(1'b0, 32'h99, 1'b0, 1'b0);
        checks++;
        if (LEVEL !== 3'd3 || R_DATA !== 32'h7 || dut_flags !== exp_flags()) begin
            errors++;
            $display("FAIL push_pop_full level=%0d rdata=%h flags=%b expected level=3 rdata=7 flags=%b",
                     LEVEL, R_DATA, dut_flags, exp_flags());
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0, 1'b0, 1'b0);
            checks++;
            if (R_DATA !== 32'h20 + 32'(i)) begin
                errors++;
                $display("FAIL dropped_word rdata=%h expected=%h", R_DATA, 32'h20 + 32'(i));
            end
        end
    endtask

    task automatic test_clear();
        logic [31:0] held;
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h30 + 32'(i), 1'b1, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h40, 1'b1, 1'b0);
        held = m_rdata;
        drive(1'b0, 32'h55, 1'b0, 1'b1);
        checks++;
        if (LEVEL !== 3'd0 || dut_flags !== 6'b101000 || R_DATA !== held) begin
            errors++;
            $display("FAIL clear level=%0d flags=%b rdata=%h expected level=0 flags=101000 rdata=%h",
                     LEVEL, dut_flags, R_DATA, held);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 32'h61, 1'b1, 1'b0);
        drive(1'b0, 32'h62, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        nRST = 1'b0;
        #2;
        model_reset();
        checks++;
        if (dut_flags !== 6'b101000 || LEVEL !== 3'd0 || R_DATA !== 32'h0 || f_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid flags=%b level=%0d rdata=%h fwft_level=%0d expected flags=101000 level=0 rdata=0",
                     dut_flags, LEVEL, R_DATA, f_level);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            checks++;
            if (LEVEL !== 3'(q.size()) || dut_flags !== exp_flags() || R_DATA !== m_rdata ||
                f_flags !== exp_flags() || (q.size() != 0 && f_r_data !== q[0])) begin
                errors++;
                $display("FAIL random cyc=%0d level=%0d flags=%b rdata=%h fwft=%h expected level=%0d flags=%b rdata=%h",
                         c, LEVEL, dut_flags, R_DATA, f_r_data, q.size(), exp_flags(), m_rdata);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_overflow_drain();
        test_fwft();
        test_back_to_back();
        test_simul_edges();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
